// File: rtl/ofdm_frame_assembler_if.sv
// Sample-stream bundle between the frame assembler and its surroundings.
// The master side drives the requests and the input samples; the slave side is the assembler.
interface ofdm_frame_assembler_if;
  localparam int unsigned SW = 8;
  localparam int unsigned NW = 8;

  logic          tx_clr;
  logic          frame_req;
  logic [NW-1:0] n_sym;
  logic          train_start;
  logic [SW-1:0] train_re;
  logic [SW-1:0] train_im;
  logic          train_dv;
  logic          train_done;
  logic [SW-1:0] sym_re;
  logic [SW-1:0] sym_im;
  logic          sym_dv;
  logic          fifo_full;
  logic          busy;
  logic [SW-1:0] tx_re;
  logic [SW-1:0] tx_im;
  logic          tx_dv;
  logic          tx_frame_start;
  logic          tx_frame_end;
  logic          overflow;
  logic          underrun;

  modport master (
    output tx_clr, frame_req, n_sym,
    output train_re, train_im, train_dv, train_done,
    output sym_re, sym_im, sym_dv,
    input  train_start, fifo_full, busy,
    input  tx_re, tx_im, tx_dv, tx_frame_start, tx_frame_end,
    input  overflow, underrun
  );

  modport slave (
    input  tx_clr, frame_req, n_sym,
    input  train_re, train_im, train_dv, train_done,
    input  sym_re, sym_im, sym_dv,
    output train_start, fifo_full, busy,
    output tx_re, tx_im, tx_dv, tx_frame_start, tx_frame_end,
    output overflow, underrun
  );
endinterface

// File: rtl/ofdm_frame_assembler.sv
// Builds one transmit frame per request: training field followed by buffered data symbols.
// Data samples are queued in an internal FIFO so the data field can follow the training field.
module ofdm_frame_assembler #(
  parameter int unsigned FIFO_AW = 8,
  parameter int unsigned SYM_LEN = 80
) (
  input logic                 clk,
  input logic                 rst,
  ofdm_frame_assembler_if.slave bus
);
  localparam int unsigned SW    = 8;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;
  localparam int unsigned LEN_W = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRAIN = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [2*SW-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [LEN_W-1:0]   smp_cnt;
  logic [LEN_W-1:0]   smp_total;
  logic               first_pend;
  logic               end_pend;

  logic               train_start;
  logic               fifo_full;
  logic               busy;
  logic [SW-1:0]      tx_re;
  logic [SW-1:0]      tx_im;
  logic               tx_dv;
  logic               tx_frame_start;
  logic               tx_frame_end;
  logic               overflow;
  logic               underrun;

  logic               clr;
  logic               accept;
  logic               emit;
  logic               pop;
  logic               starve;
  logic               last;
  logic               full_now;
  logic               wr_en;
  logic               drop;
  logic [SW-1:0]      emit_re;
  logic [SW-1:0]      emit_im;

  assign clr = rst | bus.tx_clr;

  // FIFO write side: a write at full only lands when a pop frees a slot the same cycle
  assign full_now  = (count == CNT_W'(DEPTH));
  assign wr_en     = bus.sym_dv & (~full_now | pop);
  assign drop      = bus.sym_dv & full_now & ~pop;
  assign count_nxt = count + CNT_W'(wr_en) - CNT_W'(pop);

  // Next state and the sample to put on the stream this cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    emit      = 1'b0;
    pop       = 1'b0;
    starve    = 1'b0;
    last      = 1'b0;
    emit_re   = '0;
    emit_im   = '0;
    case (state)
      S_IDLE: begin
        if (bus.frame_req) begin
          accept    = 1'b1;
          state_nxt = S_TRAIN;
        end
      end
      S_TRAIN: begin
        if (bus.train_dv) begin
          emit    = 1'b1;
          emit_re = bus.train_re;
          emit_im = bus.train_im;
        end
        if (bus.train_done) begin
          if (smp_total == '0) begin
            last      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (count >= CNT_W'(SYM_LEN)) state_nxt = S_DATA;
      end
      S_DATA: begin
        // Stream never pauses: an empty FIFO yields a zero sample and flags underrun
        emit = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          emit_re = mem[rd_ptr][2*SW-1:SW];
          emit_im = mem[rd_ptr][SW-1:0];
        end else begin
          starve = 1'b1;
        end
        if (smp_cnt == smp_total - LEN_W'(1)) begin
          last      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage is not reset; flushing the pointers is enough
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= {bus.sym_re, bus.sym_im};
  end

  // State, FIFO bookkeeping, counters and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      smp_cnt        <= '0;
      smp_total      <= '0;
      first_pend     <= 1'b0;
      end_pend       <= 1'b0;
      train_start    <= 1'b0;
      fifo_full      <= 1'b0;
      busy           <= 1'b0;
      tx_re          <= '0;
      tx_im          <= '0;
      tx_dv          <= 1'b0;
      tx_frame_start <= 1'b0;
      tx_frame_end   <= 1'b0;
      overflow       <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      fifo_full <= (count_nxt == CNT_W'(DEPTH));
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)   rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (drop)   overflow <= 1'b1;
      if (starve) underrun <= 1'b1;

      if (emit) first_pend <= 1'b0;
      if (accept) begin
        smp_total  <= LEN_W'(bus.n_sym) * LEN_W'(SYM_LEN);
        smp_cnt    <= '0;
        first_pend <= 1'b1;
      end else if (state == S_DATA) begin
        smp_cnt <= smp_cnt + LEN_W'(1);
      end

      train_start    <= accept;
      busy           <= (state_nxt != S_IDLE);
      tx_dv          <= emit;
      tx_re          <= emit_re;
      tx_im          <= emit_im;
      tx_frame_start <= emit & first_pend;
      // End marker lands one cycle after the last sample it follows
      end_pend       <= last;
      tx_frame_end   <= end_pend;
    end
  end

  assign bus.train_start    = train_start;
  assign bus.fifo_full      = fifo_full;
  assign bus.busy           = busy;
  assign bus.tx_re          = tx_re;
  assign bus.tx_im          = tx_im;
  assign bus.tx_dv          = tx_dv;
  assign bus.tx_frame_start = tx_frame_start;
  assign bus.tx_frame_end   = tx_frame_end;
  assign bus.overflow       = overflow;
  assign bus.underrun       = underrun;
endmodule
